// File: rtl/mips_vec_pkg.sv
// Shared types for the mips vector engine: FSM states, check-select encoding
// and the packed vector-buffer entry.
package mips_vec_pkg;

   // Stored field width of a buffer entry; the top casts its DATA_W ports to it.
   localparam int VEC_DATA_W = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PREP  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } vec_state_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_WD   = 2'd2,
      SEL_PC   = 2'd3
   } vec_sel_t;

   typedef struct packed {
      logic [VEC_DATA_W-1:0] instr;
      logic [VEC_DATA_W-1:0] rdata;
      logic [VEC_DATA_W-1:0] exp_val;
      vec_sel_t              sel;
   } vec_entry_t;

endpackage

// File: rtl/mips_vec_buf.sv
// Vector buffer: DEPTH packed entries, one write port, one asynchronous read port.
module mips_vec_buf
   import mips_vec_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  vec_entry_t               wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output vec_entry_t               rdata
);
   localparam int IDX_W = $clog2(DEPTH);

   vec_entry_t mem [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (we && (waddr == IDX_W'(gi))) begin
               mem[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign rdata = mem[raddr];

endmodule

// File: rtl/mips_vector_engine.sv
// Stimulus-and-check engine for the single-cycle mips core: drives one buffered
// vector per cycle and scores results. Option macro: MIPS_VEC_HALT_ON_FAIL_EN.
module mips_vector_engine
   import mips_vec_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 16,
   parameter int RST_CYC = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [DATA_W-1:0]          ld_instr,
   input  logic [DATA_W-1:0]          ld_rdata,
   input  logic [DATA_W-1:0]          ld_expect,
   input  logic [1:0]                 ld_sel,
   input  logic                       clear,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     pass_cnt,
   output logic [$clog2(DEPTH):0]     fail_cnt,
   output logic                       fail_seen,
   output logic [$clog2(DEPTH)-1:0]   first_fail_idx,
   output logic                       dut_reset,
   output logic [DATA_W-1:0]          dut_instr,
   output logic [DATA_W-1:0]          dut_readData,
   input  logic [DATA_W-1:0]          dut_pc,
   input  logic [DATA_W-1:0]          dut_aluout,
   input  logic [DATA_W-1:0]          dut_writeData,
   input  logic                       dut_memWrite
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int RC_W  = $clog2(RST_CYC + 1);
`ifdef MIPS_VEC_HALT_ON_FAIL_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   vec_state_t         state_reg, state_next;
   logic [CNT_W-1:0]   count_reg, pass_cnt_reg, fail_cnt_reg;
   logic [IDX_W-1:0]   idx_reg, first_fail_idx_reg, pc_idx_reg;
   logic [RC_W-1:0]    rst_cnt_reg;
   logic               fail_seen_reg, pc_pend_reg;
   logic [DATA_W-1:0]  pc_exp_reg;

   vec_entry_t wr_entry, rd_entry;
   logic       ld_we, vec_chk, vec_ok, pc_chk, pc_ok, any_fail, last_vec;

   assign wr_entry.instr   = VEC_DATA_W'(ld_instr);
   assign wr_entry.rdata   = VEC_DATA_W'(ld_rdata);
   assign wr_entry.exp_val = VEC_DATA_W'(ld_expect);
   assign wr_entry.sel     = vec_sel_t'(ld_sel);
   assign ld_we = (state_reg == S_IDLE) && ld_valid && ld_ready && !clear && !start;

   mips_vec_buf #(.DEPTH(DEPTH)) u_buf (
      .clk   (clk),
      .we    (ld_we),
      .waddr (count_reg[IDX_W-1:0]),
      .wdata (wr_entry),
      .raddr (idx_reg),
      .rdata (rd_entry)
   );

   // ALU/WD results belong to the vector on the bus now; PC results to the previous one.
   always_comb begin
      vec_chk = 1'b0;
      vec_ok  = 1'b0;
      if (state_reg == S_RUN) begin
         case (rd_entry.sel)
            SEL_ALU: begin
               vec_chk = 1'b1;
               vec_ok  = (dut_aluout == DATA_W'(rd_entry.exp_val));
            end
            SEL_WD: begin
               vec_chk = 1'b1;
               vec_ok  = dut_memWrite && (dut_writeData == DATA_W'(rd_entry.exp_val));
            end
            default: ;
         endcase
      end
   end

   assign pc_chk   = pc_pend_reg && ((state_reg == S_RUN) || (state_reg == S_DRAIN));
   assign pc_ok    = (dut_pc == pc_exp_reg);
   assign any_fail = (vec_chk && !vec_ok) || (pc_chk && !pc_ok);
   assign last_vec = ({1'b0, idx_reg} == (count_reg - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (clear)      state_next = S_IDLE;
            else if (start) state_next = (count_reg == '0) ? S_DONE : S_PREP;
         end
         S_PREP:  if (rst_cnt_reg == RC_W'(RST_CYC)) state_next = S_RUN;
         S_RUN: begin
            if (HALT && any_fail) state_next = S_DONE;
            else if (last_vec)    state_next = S_DRAIN;
         end
         S_DRAIN: state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
   end

   // The first PREP cycle keeps the core out of reset so the pulse is exactly RST_CYC long.
   always_comb begin
      busy         = (state_reg == S_PREP) || (state_reg == S_RUN) || (state_reg == S_DRAIN);
      done         = (state_reg == S_DONE);
      ld_ready     = (state_reg == S_IDLE) && (count_reg < CNT_W'(DEPTH));
      dut_reset    = (state_reg == S_PREP) && (rst_cnt_reg != '0);
      dut_instr    = '0;
      dut_readData = '0;
      if (state_reg == S_RUN) begin
         dut_instr    = DATA_W'(rd_entry.instr);
         dut_readData = DATA_W'(rd_entry.rdata);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg          <= '0;
         idx_reg            <= '0;
         rst_cnt_reg        <= '0;
         pass_cnt_reg       <= '0;
         fail_cnt_reg       <= '0;
         fail_seen_reg      <= 1'b0;
         first_fail_idx_reg <= '0;
         pc_pend_reg        <= 1'b0;
         pc_exp_reg         <= '0;
         pc_idx_reg         <= '0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               pc_pend_reg <= 1'b0;
               if (clear || start) begin
                  pass_cnt_reg       <= '0;
                  fail_cnt_reg       <= '0;
                  fail_seen_reg      <= 1'b0;
                  first_fail_idx_reg <= '0;
                  rst_cnt_reg        <= '0;
                  idx_reg            <= '0;
               end
               if (clear)      count_reg <= '0;
               else if (ld_we) count_reg <= count_reg + CNT_W'(1);
            end
            S_PREP: begin
               idx_reg <= '0;
               if (rst_cnt_reg != RC_W'(RST_CYC)) rst_cnt_reg <= rst_cnt_reg + RC_W'(1);
            end
            S_RUN, S_DRAIN: begin
               pass_cnt_reg <= pass_cnt_reg + CNT_W'(vec_chk && vec_ok) + CNT_W'(pc_chk && pc_ok);
               fail_cnt_reg <= fail_cnt_reg + CNT_W'(vec_chk && !vec_ok) + CNT_W'(pc_chk && !pc_ok);
               // A pending PC check always belongs to an earlier index than the live vector.
               if (any_fail && !fail_seen_reg) begin
                  fail_seen_reg      <= 1'b1;
                  first_fail_idx_reg <= (pc_chk && !pc_ok) ? pc_idx_reg : idx_reg;
               end
               pc_pend_reg <= (state_reg == S_RUN) && (rd_entry.sel == SEL_PC) &&
                              (state_next != S_DONE);
               pc_exp_reg  <= DATA_W'(rd_entry.exp_val);
               pc_idx_reg  <= idx_reg;
               if (state_reg == S_RUN) idx_reg <= idx_reg + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign pass_cnt       = pass_cnt_reg;
   assign fail_cnt       = fail_cnt_reg;
   assign fail_seen      = fail_seen_reg;
   assign first_fail_idx = first_fail_idx_reg;

endmodule

// File: tb/tb_mips_vector_engine.sv
// Directed bench for mips_vector_engine with a small behavioural single-cycle
// mips core as the device under stimulus and a run-result scoreboard.
module tb_mips_vector_engine;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 16;
   localparam int RST_CYC = 2;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int IDX_W   = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              ld_valid = 1'b0, clear = 1'b0, start = 1'b0;
   logic              ld_ready, busy, done, fail_seen, dut_reset;
   logic [DATA_W-1:0] ld_instr = '0, ld_rdata = '0, ld_expect = '0;
   logic [1:0]        ld_sel = '0;
   logic [CNT_W-1:0]  pass_cnt, fail_cnt;
   logic [IDX_W-1:0]  first_fail_idx;
   logic [DATA_W-1:0] dut_instr, dut_readData;
   logic [31:0]       m_pc, m_alu, m_wd;
   logic              m_mw;

   int total = 0;
   int passed = 0;
   int failed = 0;

   typedef struct {
      int pass_n; int fail_n; int seen; int ffi; int cyc; int rst;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   mips_vector_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RST_CYC(RST_CYC)) dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_instr(ld_instr), .ld_rdata(ld_rdata), .ld_expect(ld_expect), .ld_sel(ld_sel),
      .clear(clear), .start(start), .busy(busy), .done(done),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
      .first_fail_idx(first_fail_idx), .dut_reset(dut_reset),
      .dut_instr(dut_instr), .dut_readData(dut_readData),
      .dut_pc(m_pc), .dut_aluout(m_alu), .dut_writeData(m_wd), .dut_memWrite(m_mw)
   );

   // Behavioural single-cycle core: ADD/SUB/AND/OR/SLT, ADDI, LW, SW, BEQ, J.
   logic [31:0] rf [32];
   logic [31:0] m_pcnext, m_wval, simm, sa, p4;
   logic [4:0]  m_wa;
   logic        m_rw;
   always_comb begin
      simm = {{16{dut_instr[15]}}, dut_instr[15:0]};
      sa   = rf[dut_instr[25:21]];
      m_wd = rf[dut_instr[20:16]];
      p4   = m_pc + 32'd4;
      m_alu = '0; m_mw = 1'b0; m_rw = 1'b0; m_wa = '0; m_wval = '0; m_pcnext = p4;
      case (dut_instr[31:26])
         6'h00: begin
            m_rw = 1'b1; m_wa = dut_instr[15:11];
            case (dut_instr[5:0])
               6'h20: m_alu = sa + m_wd;
               6'h22: m_alu = sa - m_wd;
               6'h24: m_alu = sa & m_wd;
               6'h25: m_alu = sa | m_wd;
               6'h2a: m_alu = {31'd0, $signed(sa) < $signed(m_wd)};
               default: m_alu = '0;
            endcase
            m_wval = m_alu;
         end
         6'h08: begin m_alu = sa + simm; m_rw = 1'b1; m_wa = dut_instr[20:16]; m_wval = m_alu; end
         6'h23: begin m_alu = sa + simm; m_rw = 1'b1; m_wa = dut_instr[20:16]; m_wval = dut_readData; end
         6'h2b: begin m_alu = sa + simm; m_mw = 1'b1; end
         6'h04: begin
            m_alu = sa - m_wd;
            if (m_alu == 32'd0) m_pcnext = p4 + (simm << 2);
         end
         6'h02: m_pcnext = {p4[31:28], dut_instr[25:0], 2'b00};
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (dut_reset) begin
         m_pc <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         m_pc <= m_pcnext;
         if (m_rw && (m_wa != 5'd0)) rf[m_wa] <= m_wval;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic load(input logic [31:0] ins, input logic [31:0] rd,
                       input logic [31:0] ex, input logic [1:0] sel);
      @(negedge clk);
      ld_instr = ins; ld_rdata = rd; ld_expect = ex; ld_sel = sel; ld_valid = 1'b1;
      @(posedge clk); #1;
      ld_valid = 1'b0;
      $display("load instr=%08h rdata=%0h expect=%0h sel=%0d ready_was=%0b", ins, rd, ex, sel, ld_ready);
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(posedge clk); #1; clear = 1'b0;
   endtask

   task automatic run(input string tag, input int e_pass, input int e_fail, input int e_seen,
                      input int e_ffi, input int e_cyc, input int e_rst);
      exp_t e;
      int cyc, rst;
      exp_q.push_back('{e_pass, e_fail, e_seen, e_ffi, e_cyc, e_rst});
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0; rst = 0;
      while (!done && cyc < 200) begin
         @(negedge clk); if (dut_reset) rst++;
         @(posedge clk); #1; cyc++;
      end
      e = exp_q.pop_front();
      $display("run %s cycles=%0d rst=%0d pass=%0d fail=%0d seen=%0b ffi=%0d",
               tag, cyc, rst, pass_cnt, fail_cnt, fail_seen, first_fail_idx);
      check({tag, "_done"}, done, 1);
      check({tag, "_cycles"}, cyc, e.cyc);
      check({tag, "_rst_len"}, rst, e.rst);
      check({tag, "_pass"}, pass_cnt, e.pass_n);
      check({tag, "_fail"}, fail_cnt, e.fail_n);
      check({tag, "_seen"}, fail_seen, e.seen);
      check({tag, "_ffi"}, first_fail_idx, e.ffi);
      check({tag, "_nop"}, dut_instr, 0);
   endtask

   localparam logic [31:0] ADDI2 = 32'h2022_0008; // addi r2,r1,8
   localparam logic [31:0] ADDI3 = 32'h2023_0010; // addi r3,r1,16
   localparam logic [31:0] SUB4  = 32'h0062_2022; // sub r4,r3,r2
   localparam logic [31:0] LW5   = 32'h8C05_0000; // lw r5,0(r0)
   localparam logic [31:0] SW5   = 32'hAC05_0004; // sw r5,4(r0)
   localparam logic [31:0] BEQ2  = 32'h1000_0002; // beq r0,r0,+2
   localparam logic [31:0] J4    = 32'h0800_0004; // j 4

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ld_ready", ld_ready, 1);
      check("rst_pass", pass_cnt, 0);
      check("rst_fail", fail_cnt, 0);
      check("rst_seen", fail_seen, 0);
      check("rst_dut_reset", dut_reset, 0);
      check("rst_instr", dut_instr, 0);
      check("rst_rdata", dut_readData, 0);

      load(ADDI2, 0, 8, 2'd1); load(ADDI3, 0, 16, 2'd1); load(SUB4, 0, 8, 2'd1);
      run("alu_ok", 3, 0, 0, 0, 1 + RST_CYC + 4, RST_CYC);

      pulse_clear();
      load(ADDI2, 0, 8, 2'd1); load(ADDI3, 0, 17, 2'd1); load(SUB4, 0, 8, 2'd1);
      run("alu_bad", 2, 1, 1, 1, 1 + RST_CYC + 4, RST_CYC);

      pulse_clear();
      load(LW5, 32'h23, 0, 2'd0); load(SW5, 0, 32'h23, 2'd2); load(SW5, 0, 32'h24, 2'd2);
      run("wd", 1, 1, 1, 2, 1 + RST_CYC + 4, RST_CYC);

      pulse_clear();
      load(BEQ2, 0, 32'hC, 2'd3); load(J4, 0, 32'h10, 2'd3);
      run("pc", 2, 0, 0, 0, 1 + RST_CYC + 3, RST_CYC);
      run("pc_rerun", 2, 0, 0, 0, 1 + RST_CYC + 3, RST_CYC);

      pulse_clear();
      load(BEQ2, 0, 32'h8, 2'd3); load(ADDI2, 0, 9, 2'd1);
      run("pc_first", 0, 2, 1, 0, 1 + RST_CYC + 3, RST_CYC);

      // start and clear together in DONE: clear wins
      @(negedge clk); start = 1'b1; clear = 1'b1;
      @(posedge clk); #1; start = 1'b0; clear = 1'b0;
      check("sc_done", done, 0);
      check("sc_busy", busy, 0);
      check("sc_pass", pass_cnt, 0);
      run("sc_empty", 0, 0, 0, 0, 0, 0);

      pulse_clear();
      for (int i = 0; i < DEPTH + 1; i++) begin
         if (i == DEPTH - 1) check("ready_last", ld_ready, 1);
         if (i == DEPTH)     check("ready_full", ld_ready, 0);
         load(ADDI2, 0, 8, 2'd1);
      end
      run("full", DEPTH, 0, 0, 0, 1 + RST_CYC + DEPTH + 1, RST_CYC);

      pulse_clear();
      run("empty", 0, 0, 0, 0, 0, 0);

      // reset in the middle of RUN
      pulse_clear();
      load(ADDI2, 0, 8, 2'd1); load(ADDI3, 0, 16, 2'd1); load(SUB4, 0, 8, 2'd1);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (1 + RST_CYC + 2) @(posedge clk);
      #1;
      check("mid_busy", busy, 1);
      check("mid_pass", pass_cnt, 2);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_pass", pass_cnt, 0);
      check("abort_ready", ld_ready, 1);
      check("abort_instr", dut_instr, 0);
      check("abort_dut_reset", dut_reset, 0);
      run("abort_empty", 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
